// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, queue entry
// layout and the fetchable-PC helper.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // A PC may be fetched only if word aligned and inside the loaded program image.
  function automatic logic pc_fetchable(input logic [31:0] pc, input logic [31:0] mem_words);
    pc_fetchable = (pc[1:0] == 2'b00) && (pc < (mem_words * WORD_BYTES));
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry fetch queue of {instr, pc}; entry 0 is always the head, so the
// head outputs come straight from a register.
module fetch_queue
  import instruction_fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count_next
);

  logic [1:0]   r_count;
  logic         r_valid;
  fetch_entry_t r_e0;
  fetch_entry_t r_e1;

  logic [1:0]   w_count_next;
  fetch_entry_t w_e0_next;
  fetch_entry_t w_e1_next;
  logic         w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  // Next queue contents: flush wins, then pop shifts entry 1 forward, then push fills the tail.
  always_comb begin
    w_e0_next    = r_e0;
    w_e1_next    = r_e1;
    w_count_next = r_count;
    if (i_flush) begin
      w_e0_next    = '0;
      w_e1_next    = '0;
      w_count_next = 2'd0;
    end else begin
      if (w_pop) begin
        w_e0_next    = r_e1;
        w_e1_next    = '0;
        w_count_next = r_count - 2'd1;
      end else begin
        w_count_next = r_count;
      end
      if (i_push && (w_count_next != 2'd2)) begin
        if (w_count_next == 2'd0) begin
          w_e0_next = i_data;
        end else begin
          w_e1_next = i_data;
        end
        w_count_next = w_count_next + 2'd1;
      end else begin
        w_count_next = w_count_next;
      end
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 2'd0;
      r_valid <= 1'b0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      r_count <= w_count_next;
      r_valid <= (w_count_next != 2'd0);
      r_e0    <= w_e0_next;
      r_e1    <= w_e1_next;
    end
  end

  assign o_valid      = r_valid;
  assign o_head       = r_e0;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, runs the memory req/ack handshake and
// feeds decode through a 2-entry tagged queue; redirects flush stale work.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_WORDS = 32'd9
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_instr,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_mem_addr;
  logic [31:0]  w_mem_addr_next;
  logic         r_mem_req;
  logic         w_mem_req_next;
  logic         r_fault;
  logic         w_fault_next;
  logic         w_redir;
  logic         w_redir_bad;
  logic         w_push;
  logic         w_pop;
  logic         w_evaluate;
  logic         w_q_valid;
  logic [1:0]   w_count_next;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  // Once faulted or halted, redirects are ignored; a redirect drops any same-cycle ack data.
  assign w_redir     = redirect_valid && (r_state != S_HALT) && !r_fault;
  assign w_redir_bad = w_redir && (redirect_pc[1:0] != 2'b00);
  assign w_push      = (r_state == S_BUSY) && mem_ack && !w_redir;
  assign w_pop       = w_q_valid && instr_ready;
  assign w_pc_next   = w_redir ? redirect_pc : (w_push ? (r_pc + WORD_BYTES) : r_pc);
  assign w_push_data = '{instr: mem_instr, pc: r_pc};

  fetch_queue u_queue (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_push       (w_push),
    .i_data       (w_push_data),
    .i_pop        (w_pop),
    .i_flush      (w_redir),
    .o_valid      (w_q_valid),
    .o_head       (w_head),
    .o_count_next (w_count_next)
  );

  // Next-state: decide when the issue rule is evaluated, then apply it to the next PC.
  always_comb begin
    w_state_next    = r_state;
    w_fault_next    = r_fault | w_redir_bad;
    w_mem_addr_next = r_mem_addr;
    w_evaluate      = 1'b0;
    case (r_state)
      S_IDLE: w_evaluate = 1'b1;
      S_BUSY: begin
        if (mem_ack) begin
          w_evaluate = 1'b1;
        end else if (w_redir) begin
          w_state_next = S_DISCARD;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      S_DISCARD: w_evaluate = mem_ack;
      S_HALT:    w_state_next = S_HALT;
      default: begin
        w_state_next = S_HALT;
        w_fault_next = 1'b1;
      end
    endcase
    if (w_evaluate) begin
      if (w_fault_next || !pc_fetchable(w_pc_next, MEM_WORDS)) begin
        w_state_next = S_HALT;
        w_fault_next = 1'b1;
      end else if (w_count_next <= 2'd1) begin
        w_state_next    = S_BUSY;
        w_mem_addr_next = w_pc_next;
      end else begin
        w_state_next = S_IDLE;
      end
    end else begin
      w_mem_addr_next = r_mem_addr;
    end
  end

  assign w_mem_req_next = (w_state_next == S_BUSY) || (w_state_next == S_DISCARD);

  // State, PC and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= 32'h0000_0000;
      r_mem_req  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_req  <= w_mem_req_next;
      r_fault    <= w_fault_next;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign fault       = r_fault;
  assign instr_valid = w_q_valid;
  assign instr_out   = w_head.instr;
  assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench: expected program-order stream from a queue model,
// a memory responder with configurable ack latency, and a delivery monitor.
module tb_instruction_fetch;

  localparam int NW = 9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_instr = 32'h0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fault;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_WORDS(32'd9)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_instr(mem_instr), .instr_valid(instr_valid),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fault(fault)
  );

  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

  logic [31:0] mem_words [NW];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          ack_delay_max = 0;
  bit          ack_random = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Program-order stream from start_pc to the last word; misaligned starts yield nothing.
  function automatic void model_load(input logic [31:0] start_pc);
    exp_q.delete();
    if (start_pc[1:0] == 2'b00) begin
      for (int a = int'(start_pc); a < 4 * NW; a += 4)
        exp_q.push_back('{instr: mem_words[a / 4], pc: 32'(a)});
    end
  endfunction

  // Monitor: every accepted head must be the next element of the expected stream.
  always @(negedge clk) begin
    if (reset_n) begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_delivery: got pc %h expected none", instr_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("deliver_pc", instr_pc, e.pc);
          check("deliver_instr", instr_out, e.instr);
        end
      end
      if (redirect_valid) model_load(redirect_pc);
    end
  end

  // Memory responder: latches each new request, holds it, acks after a delay.
  bit          rsp_active = 1'b0;
  int          rsp_wait = 0;
  logic [31:0] rsp_addr = 32'h0;
  always begin
    @(posedge clk);
    #2;
    if (!reset_n) begin
      rsp_active = 1'b0;
      mem_ack = 1'b0;
    end else begin
      if (mem_ack) rsp_active = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_addr = mem_addr;
          req_log.push_back(mem_addr);
          rsp_wait = ack_random ? int'($urandom_range(0, ack_delay_max)) : ack_delay_max;
          check("req_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
          check("req_in_range", {31'd0, (mem_addr < 32'd36)}, 32'd1);
        end else begin
          check("req_addr_stable", mem_addr, rsp_addr);
        end
        if (rsp_wait == 0) begin
          mem_ack = 1'b1;
          mem_instr = (mem_addr < 32'd36) ? mem_words[mem_addr[5:2]] : 32'hDEAD_BEEF;
        end else begin
          rsp_wait--;
        end
      end else if (rsp_active) begin
        check("req_held_until_ack", {31'd0, mem_req}, 32'd1);
        rsp_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_reset();
    redirect_valid = 1'b0;
    model_load(32'h0);
    req_log.delete();
    repeat (2) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    finish_reset();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    instr_ready = 1'b1;
    while (!(fault && !instr_valid && !mem_req) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
    end
    check("stream_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic redirect_pulse(input logic [31:0] target);
    redirect_pc = target;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int snap;
    mem_words[0] = 32'h0232_4020;
    for (int i = 1; i < NW; i++) mem_words[i] = $urandom;

    // Zero-wait memory, decode always ready: one instruction per cycle, then halt.
    ack_random = 1'b0; ack_delay_max = 0; instr_ready = 1'b1;
    tick();
    finish_reset();
    tick();
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'd0);
    check("first_valid_late", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < NW; i++) begin
      tick();
      check("stream_valid", {31'd0, instr_valid}, 32'd1);
      check("stream_pc", instr_pc, 32'(4 * i));
      if (i == 0) check("word0", instr_out, 32'h0232_4020);
      if (i == NW - 1) begin
        check("end_fault", {31'd0, fault}, 32'd1);
        check("end_no_req", {31'd0, mem_req}, 32'd0);
      end
    end
    tick();
    check("end_drained", {31'd0, instr_valid}, 32'd0);
    drain(20);

    // Decode stalled: queue fills with pc 0 and 4, then resumes with no gap.
    instr_ready = 1'b0;
    apply_reset();
    repeat (5) tick();
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    check("stall_head", instr_pc, 32'd0);
    check("stall_no_req", {31'd0, mem_req}, 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("resume_pc", instr_pc, 32'(4 * (i + 1)));
    end
    drain(20);

    // Redirect with a full queue.
    instr_ready = 1'b0;
    apply_reset();
    repeat (5) tick();
    redirect_pulse(32'h10);
    check("flush_valid", {31'd0, instr_valid}, 32'd0);
    drain(40);

    // Slow memory: redirect while pc 8 outstanding drops its data.
    ack_delay_max = 3; instr_ready = 1'b1;
    apply_reset();
    k = 0;
    while (!(mem_req && mem_addr == 32'h8) && k < 40) begin tick(); k++; end
    check("saw_req_8", {31'd0, (k < 40)}, 32'd1);
    redirect_pulse(32'h18);
    drain(100);
    k = -1;
    foreach (req_log[i]) if (k < 0 && req_log[i] == 32'h8) k = i;
    if (k >= 0 && k + 1 < req_log.size()) check("redirect_next_addr", req_log[k + 1], 32'h18);
    else begin
      n_tests++; n_fail++;
      $display("FAIL redirect_next_addr: got none expected 00000018");
    end

    // Misaligned redirect: fault, no further requests, queue stays empty.
    ack_delay_max = 0;
    apply_reset();
    repeat (3) tick();
    redirect_pulse(32'h6);
    snap = req_log.size();
    repeat (5) tick();
    check("misal_fault", {31'd0, fault}, 32'd1);
    check("misal_no_req", {31'd0, mem_req}, 32'd0);
    check("misal_empty", {31'd0, instr_valid}, 32'd0);
    check("misal_req_count", 32'(req_log.size()), 32'(snap));
    drain(10);

    // Asynchronous reset in the middle of a busy fetch.
    ack_delay_max = 3;
    apply_reset();
    k = 0;
    while (!(mem_req && instr_valid) && k < 40) begin tick(); k++; end
    check("saw_busy", {31'd0, (k < 40)}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_req", {31'd0, mem_req}, 32'd0);
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("async_fault", {31'd0, fault}, 32'd0);
    finish_reset();
    tick();
    check("post_rst_req", {31'd0, mem_req}, 32'd1);
    check("post_rst_addr", mem_addr, 32'h0);
    drain(200);

    // Randomized phases: ack latency, decode backpressure and redirects.
    for (int p = 0; p < 6; p++) begin
      ack_random = 1'b1;
      ack_delay_max = int'($urandom_range(0, 3));
      instr_ready = 1'b1;
      apply_reset();
      for (int c = 0; c < 150; c++) begin
        tick();
        instr_ready = ($urandom_range(0, 3) != 0);
        if (redirect_valid) redirect_valid = 1'b0;
        else if (!fault && $urandom_range(0, 9) == 0) begin
          int r;
          r = int'($urandom_range(0, 19));
          if (r == 0) redirect_pc = 32'(4 * $urandom_range(0, 8) + 2);
          else if (r == 1) redirect_pc = 32'(36 + 4 * $urandom_range(0, 1));
          else redirect_pc = 32'(4 * $urandom_range(0, 8));
          redirect_valid = 1'b1;
        end
      end
      if (redirect_valid) begin tick(); redirect_valid = 1'b0; end
      drain(400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit that drives the instruction memory and supplies the decode stage. Holds the program counter, issues word-aligned byte addresses to the memory through a req/ack handshake, and buffers returned words in a 2-entry fetch queue with PC tags toward decode (valid/ready). Accepts branch/jump redirects from decode, flushing stale work. Sits between the instruction memory and the register-read/decode stage.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset
- MEM_WORDS, 9: number of valid instruction words; legal PCs are 0 .. 4*MEM_WORDS-4
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  byte address of request; low 2 bits always 0
- mem_ack  in  1  memory has returned data for current request
- mem_instr  in  32  instruction word, valid when mem_ack
- instr_valid  out  1  queue head valid toward decode
- instr_out  out  32  queue head instruction
- instr_pc  out  32  byte address of instr_out
- instr_ready  in  1  decode accepts head this cycle
- redirect_valid  in  1  branch/jump taken; single-cycle pulse
- redirect_pc  in  32  new fetch byte address
- fault  out  1  sticky: PC out of range or misaligned redirect

## Operation
- State machine, 2-bit: IDLE (no request outstanding), BUSY (request outstanding), DISCARD (outstanding, result to be dropped), HALT.
- mem_req = 1 in BUSY and DISCARD only; mem_addr = pc register in BUSY, address of the abandoned request in DISCARD. Once raised, mem_req and mem_addr hold stable until mem_ack.
- Push: BUSY and mem_ack -> write {mem_instr, pc} at queue tail, pc <= pc + 4 (32-bit wrap, irrelevant given range check).
- Pop: instr_valid and instr_ready -> advance head. Push and pop in the same cycle are both performed.
- Issue: from IDLE, or from BUSY on the ack cycle, stay/enter BUSY iff occupancy after this cycle's push/pop is <= 1 and the next pc is in range and aligned; else IDLE.
- Range check: next pc >= 4*MEM_WORDS -> HALT, fault = 1; no request issued.
- Redirect (priority over push/pop): queue flushed (occupancy 0, instr_valid 0 next cycle), pc <= redirect_pc. A pop in the same cycle counts as completed. BUSY without ack -> DISCARD; ack in the redirect cycle -> data dropped, next state per issue rule with new pc.
- DISCARD: on mem_ack, data dropped; then issue rule applies.
- Misaligned redirect_pc (bits[1:0] != 0): fault set; HALT directly, or via DISCARD if a request is outstanding.
- HALT: no requests; queue still drains to decode; redirects ignored; exit only by reset.

## Timing
- Reset (async assert): pc = RESET_PC, state IDLE, queue empty, mem_req 0, mem_addr 0, instr_valid 0, instr_out 0, instr_pc 0, fault 0. First mem_req on the first rising edge after deassertion.
- Zero-wait memory (ack in the same cycle as req), decode always ready: one instruction per cycle; first instr_valid 1 cycle after first mem_req.
- Fetch latency: instr_valid rises the cycle after mem_ack.
- Redirect to first new mem_req: 1 cycle (no outstanding request), or 1 cycle after the abandoned request's ack.
- Queue full (2 entries) and decode stalled: mem_req stays 0; no loss, no duplication.

## Structure
- Shared package: FSM state encoding, WORD_BYTES = 4, NOP/zero instruction constant, pc range helper.
- Sub-module: fetch_queue (2-entry FIFO of {instr, pc}, push/pop/flush, count 0..2).

## Test plan
- Reset, memory loaded with 9 words (word 0 = 32'h02324020), zero-wait ack, ready = 1 -> instr_pc 0, 4, ..., 32 on consecutive cycles, then fault = 1 and mem_req 0 after pc 32.
- instr_ready = 0 for 5 cycles from reset -> queue holds pc 0 and 4, mem_req low; release -> pc 8 follows with no gap or duplicate.
- Ack delayed 3 cycles, redirect_pc = 32'h18 while BUSY at pc 8 -> data for pc 8 dropped after ack, next mem_addr = 32'h18, instr_pc 24 follows.
- Redirect with 2 entries queued -> instr_valid 0 next cycle, next delivered instr_pc = redirect_pc.
- redirect_pc = 32'h0000_0006 -> fault = 1, no further mem_req, queue not refilled.
- reset_n asserted mid-BUSY -> mem_req, instr_valid, fault drop immediately; after release mem_addr = RESET_PC.
